// File: rtl/lfsr_checker.sv
// Serial PRBS checker: self-seeds a local Fibonacci LFSR from the incoming
// bitstream, then verifies each received bit and tracks lock, errors and bits.
module lfsr_checker #(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] TAPS     = 8'hB8,
  parameter int               LOCK_CNT = 16,
  parameter int               LOSS_CNT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        in_valid,
  input  logic        in_bit,
  input  logic        clear_cnt,
  output logic        locked,
  output logic        err_pulse,
  output logic [15:0] err_cnt,
  output logic [31:0] bit_cnt
);

  localparam int FW = $clog2(WIDTH + 1);
  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int LW = $clog2(LOSS_CNT + 1);

  localparam logic [FW-1:0] FILL_LAST  = FW'(WIDTH - 1);
  localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_CNT - 1);
  localparam logic [LW-1:0] MISS_LAST  = LW'(LOSS_CNT - 1);

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t            state;
  logic [WIDTH-1:0]  sr;
  logic [FW-1:0]     fill_cnt;
  logic [MW-1:0]     match_cnt;
  logic [LW-1:0]     miss_cnt;

  logic              pred;
  logic              mismatch;
  logic [WIDTH-1:0]  shift_in;
  logic [WIDTH-1:0]  shift_pred;
  logic [15:0]       err_base;
  logic [15:0]       err_next;
  logic [31:0]       bit_base;
  logic [31:0]       bit_next;

  // A clear in the same cycle as a counted beat is applied before the beat
  // is added, so the counters restart at one rather than zero.
  always_comb begin
    pred       = ^(sr & TAPS);
    mismatch   = (in_bit != pred);
    shift_in   = {sr[WIDTH-2:0], in_bit};
    shift_pred = {sr[WIDTH-2:0], pred};
    err_base   = clear_cnt ? 16'd0 : err_cnt;
    bit_base   = clear_cnt ? 32'd0 : bit_cnt;
    err_next   = (&err_base) ? err_base : err_base + 16'd1;
    bit_next   = (&bit_base) ? bit_base : bit_base + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FILL;
      sr        <= '0;
      fill_cnt  <= '0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_cnt   <= '0;
      bit_cnt   <= '0;
    end else begin
      err_pulse <= 1'b0;
      if (enable) begin
        if (clear_cnt) begin
          err_cnt <= '0;
          bit_cnt <= '0;
        end
        if (in_valid) begin
          case (state)
            FILL: begin
              sr <= shift_in;
              if (fill_cnt == FILL_LAST) begin
                fill_cnt <= '0;
                // An all-zero register would predict zeros forever, so refill.
                if (|shift_in) begin
                  state     <= VERIFY;
                  match_cnt <= '0;
                end
              end else begin
                fill_cnt <= fill_cnt + FW'(1);
              end
            end

            VERIFY: begin
              sr <= shift_in;
              if (!mismatch) begin
                if (match_cnt == MATCH_LAST) begin
                  state    <= LOCKED;
                  locked   <= 1'b1;
                  miss_cnt <= '0;
                end else begin
                  match_cnt <= match_cnt + MW'(1);
                end
              end else begin
                state    <= FILL;
                fill_cnt <= '0;
              end
            end

            LOCKED: begin
              // Free-running prediction: one corrupted bit costs one count.
              sr      <= shift_pred;
              bit_cnt <= bit_next;
              if (mismatch) begin
                err_pulse <= 1'b1;
                err_cnt   <= err_next;
                if (miss_cnt == MISS_LAST) begin
                  state    <= FILL;
                  locked   <= 1'b0;
                  fill_cnt <= '0;
                  miss_cnt <= '0;
                end else begin
                  miss_cnt <= miss_cnt + LW'(1);
                end
              end else begin
                miss_cnt <= '0;
              end
            end

            default: begin
              state    <= FILL;
              locked   <= 1'b0;
              fill_cnt <= '0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker: drives a PRBS from a generator model and
// compares outputs against hand-derived expected values.
module tb_lfsr_checker;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        in_valid;
  logic        in_bit;
  logic        clear_cnt;
  logic        locked;
  logic        err_pulse;
  logic [15:0] err_cnt;
  logic [31:0] bit_cnt;

  int          vectors;
  int          miscompares;
  int          pulse_cnt;
  logic        locked_seen;
  logic [7:0]  gen_state;

  lfsr_checker dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .clear_cnt (clear_cnt),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_cnt   (err_cnt),
    .bit_cnt   (bit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic next_gen(output logic b);
    b         = ^(gen_state & 8'hB8);
    gen_state = {gen_state[6:0], b};
  endtask

  task automatic sample_outputs();
    pulse_cnt += int'(err_pulse);
    if (locked) locked_seen = 1'b1;
  endtask

  task automatic apply_stimulus(input logic b, input logic clr);
    @(negedge clk);
    enable    = 1'b1;
    in_valid  = 1'b1;
    in_bit    = b;
    clear_cnt = clr;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    clear_cnt = 1'b0;
    sample_outputs();
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    in_valid = 1'b0;
    in_bit   = 1'($urandom);
    @(posedge clk);
    #1;
    sample_outputs();
  endtask

  task automatic send_gen(input int n, input logic inv);
    logic b;
    for (int i = 0; i < n; i++) begin
      next_gen(b);
      apply_stimulus(b ^ inv, 1'b0);
    end
  endtask

  task automatic send_gen_gappy(input int n);
    logic b;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 1) == 1) idle_cycle();
      next_gen(b);
      apply_stimulus(b, 1'b0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    enable    = 1'b1;
    in_valid  = 1'b0;
    in_bit    = 1'b0;
    clear_cnt = 1'b0;
    @(negedge clk);
    rst_n       = 1'b1;
    pulse_cnt   = 0;
    locked_seen = 1'b0;
    gen_state   = 8'h55;
  endtask

  initial begin
    logic [31:0] held_bits;
    logic        hold_ok;
    logic        b;

    vectors     = 0;
    miscompares = 0;
    pulse_cnt   = 0;
    locked_seen = 1'b0;
    gen_state   = 8'h55;
    rst_n       = 1'b0;
    enable      = 1'b0;
    in_valid    = 1'b0;
    in_bit      = 1'b0;
    clear_cnt   = 1'b0;

    #12;
    check_output("reset_locked", 32'(locked), 32'd0);
    check_output("reset_pulse", 32'(err_pulse), 32'd0);
    check_output("reset_err", 32'(err_cnt), 32'd0);
    check_output("reset_bits", bit_cnt, 32'd0);

    // Clean stream: lock after beat 24, 76 locked beats out of 100.
    do_reset();
    send_gen(23, 1'b0);
    check_output("clean_unlocked_b23", 32'(locked), 32'd0);
    send_gen(1, 1'b0);
    check_output("clean_locked_b24", 32'(locked), 32'd1);
    send_gen(76, 1'b0);
    check_output("clean_pulses", pulse_cnt, 32'd0);
    check_output("clean_err", 32'(err_cnt), 32'd0);
    check_output("clean_bits", bit_cnt, 32'd76);

    // Single inverted bit at beat 50.
    do_reset();
    send_gen(49, 1'b0);
    send_gen(1, 1'b1);
    send_gen(50, 1'b0);
    check_output("single_pulses", pulse_cnt, 32'd1);
    check_output("single_err", 32'(err_cnt), 32'd1);
    check_output("single_locked", 32'(locked), 32'd1);
    check_output("single_bits", bit_cnt, 32'd76);

    // Eight consecutive errors drop lock; relock after 24 clean beats.
    do_reset();
    send_gen(24, 1'b0);
    pulse_cnt = 0;
    send_gen(7, 1'b1);
    check_output("loss_locked_e7", 32'(locked), 32'd1);
    send_gen(1, 1'b1);
    check_output("loss_unlocked_e8", 32'(locked), 32'd0);
    check_output("loss_err", 32'(err_cnt), 32'd8);
    check_output("loss_pulses", pulse_cnt, 32'd8);
    check_output("loss_bits", bit_cnt, 32'd8);
    send_gen(23, 1'b0);
    check_output("relock_pending", 32'(locked), 32'd0);
    check_output("relock_bits_hold", bit_cnt, 32'd8);
    send_gen(1, 1'b0);
    check_output("relock_locked", 32'(locked), 32'd1);
    check_output("relock_bits", bit_cnt, 32'd8);

    // All-zero input never locks.
    do_reset();
    for (int i = 0; i < 64; i++) apply_stimulus(1'b0, 1'b0);
    check_output("zero_never_locked", 32'(locked_seen), 32'd0);
    check_output("zero_err", 32'(err_cnt), 32'd0);
    check_output("zero_bits", bit_cnt, 32'd0);

    // Bad bit at VERIFY beat 5 forces a full refill.
    do_reset();
    send_gen(12, 1'b0);
    send_gen(1, 1'b1);
    send_gen(23, 1'b0);
    check_output("verify_fail_pending", 32'(locked), 32'd0);
    send_gen(1, 1'b0);
    check_output("verify_fail_relock", 32'(locked), 32'd1);
    check_output("verify_fail_err", 32'(err_cnt), 32'd0);

    // Random gaps plus enable low for 10 cycles mid-lock.
    do_reset();
    send_gen_gappy(24);
    check_output("gap_locked", 32'(locked), 32'd1);
    send_gen_gappy(20);
    held_bits = bit_cnt;
    hold_ok   = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      enable    = 1'b0;
      in_valid  = 1'b1;
      in_bit    = 1'($urandom);
      clear_cnt = 1'b1;
      @(posedge clk);
      #1;
      if (locked !== 1'b1 || err_pulse !== 1'b0 || bit_cnt !== held_bits || err_cnt !== 16'd0)
        hold_ok = 1'b0;
    end
    enable    = 1'b1;
    in_valid  = 1'b0;
    clear_cnt = 1'b0;
    check_output("enable_hold", 32'(hold_ok), 32'd1);
    send_gen_gappy(20);
    check_output("gap_bits", bit_cnt, 32'd40);
    check_output("gap_err", 32'(err_cnt), 32'd0);
    check_output("gap_pulses", pulse_cnt, 32'd0);

    // Clear coinciding with a mismatching beat.
    next_gen(b);
    apply_stimulus(~b, 1'b1);
    check_output("clear_err_pulse", 32'(err_pulse), 32'd1);
    check_output("clear_err", 32'(err_cnt), 32'd1);
    check_output("clear_bits", bit_cnt, 32'd1);

    // Error counter saturation.
    @(negedge clk);
    force dut.err_cnt = 16'hFFFF;
    #1;
    release dut.err_cnt;
    next_gen(b);
    apply_stimulus(~b, 1'b0);
    check_output("sat_pulse", 32'(err_pulse), 32'd1);
    check_output("sat_err", 32'(err_cnt), 32'h0000_FFFF);
    send_gen(2, 1'b0);
    check_output("sat_locked", 32'(locked), 32'd1);

    // Asynchronous reset mid-lock, between clock edges.
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("async_locked", 32'(locked), 32'd0);
    check_output("async_err", 32'(err_cnt), 32'd0);
    check_output("async_bits", bit_cnt, 32'd0);
    check_output("async_pulse", 32'(err_pulse), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
